// File: rtl/delay_window_pkg.sv
// ---------------------------------------------------------------------------
// delay_pkg
// Shared definitions for the delay_window line-buffer block.
//   MIN_WIDTH   : smallest line width the line buffers can operate on
//   pix_width() : pixel width in bits from channel width and channel count
//   clamp_width : maps a requested line width onto [MIN_WIDTH, depth]
// ---------------------------------------------------------------------------
package delay_pkg;

  // Two columns per line is the floor: one column is always being read while
  // the previously visited column is being written.
  localparam int MIN_WIDTH = 2;

  function automatic int pix_width(input int img_width, input int channel_nb);
    return img_width * channel_nb;
  endfunction

  function automatic int clamp_width(input int req, input int depth);
    if (req < MIN_WIDTH) begin
      return MIN_WIDTH;
    end else if (req > depth) begin
      return depth;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/delay_window_if.sv
// ---------------------------------------------------------------------------
// delay_window_if
// Pixel stream in, pixel column out.
//   up_data/up_val/up_rdy : input pixel stream, channel 0 in the LSBs
//   dn_bus/dn_val/dn_rdy  : output column, slot h = pixel h lines earlier
//   dn_eol                : qualified by dn_val, column is last x of its line
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer keeps data and valid stable while valid=1 and
// ready=0; ready may depend on registered state and on the opposite side's
// ready, never on the same side's valid.
//
// master : the side that feeds pixels and consumes columns
// slave  : the delay_window block itself
// ---------------------------------------------------------------------------
interface delay_window_if #(
  parameter int PIX_W     = 8,
  parameter int HEIGHT_NB = 3
) ();

  logic [PIX_W-1:0]           up_data;
  logic                       up_val;
  logic                       up_rdy;
  logic [PIX_W*HEIGHT_NB-1:0] dn_bus;
  logic                       dn_val;
  logic                       dn_rdy;
  logic                       dn_eol;

  modport master (
    output up_data, up_val, dn_rdy,
    input  up_rdy, dn_bus, dn_val, dn_eol
  );

  modport slave (
    input  up_data, up_val, dn_rdy,
    output up_rdy, dn_bus, dn_val, dn_eol
  );

endinterface

// File: rtl/delay_window_line_mem.sv
// ---------------------------------------------------------------------------
// line_mem
// Simple dual-port RAM holding one image line, registered read.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write column
//   i_wdata : write pixel
//   i_raddr : read column, data appears on o_rdata after the next edge
//   o_rdata : read pixel (old contents on a same-address read/write)
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module line_mem #(
  parameter int W     = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 1 << AW
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/delay_window.sv
// ---------------------------------------------------------------------------
// delay_window
// Buffers HEIGHT_NB-1 image lines and presents a vertical column of
// HEIGHT_NB pixels at the same x position to the downstream filter.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   cfg_width : line width in pixels, sampled on cfg_set (clamped)
//   cfg_set   : load width and restart the frame; beats that cycle are dropped
//   bus       : slave side of delay_window_if (pixel stream / column stream)
// ---------------------------------------------------------------------------
module delay_window
  import delay_pkg::*;
#(
  parameter int HEIGHT_NB  = 3,
  parameter int IMG_WIDTH  = 8,
  parameter int CHANNEL_NB = 1,
  parameter int MEM_AWIDTH = 12,
  parameter int MEM_DEPTH  = 1 << MEM_AWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MEM_AWIDTH:0] cfg_width,
  input  logic                cfg_set,
  delay_window_if.slave       bus
);

  localparam int PIX_W = pix_width(IMG_WIDTH, CHANNEL_NB);
  localparam int NM    = HEIGHT_NB - 1;
  localparam int RW    = $clog2(HEIGHT_NB);

  logic [MEM_AWIDTH-1:0]      r_col;
  logic [RW-1:0]              r_rows;
  logic [MEM_AWIDTH:0]        r_width;
  logic [PIX_W-1:0]           r_slot [HEIGHT_NB];
  logic                       r_dn_val;
  logic                       r_dn_eol;

  logic                       w_up_rdy;
  logic                       w_accept;
  logic                       w_col_last;
  logic                       w_primed;
  logic [MEM_AWIDTH-1:0]      w_col_nxt;
  logic [PIX_W-1:0]           w_rd [NM];
  logic [PIX_W-1:0]           w_wr [NM];
  logic [PIX_W*HEIGHT_NB-1:0] w_dn_bus;

  assign w_up_rdy   = ~cfg_set & (~r_dn_val | bus.dn_rdy);
  assign w_accept   = bus.up_val & w_up_rdy;
  assign w_col_last = ({1'b0, r_col} == (r_width - 1'b1));
  assign w_primed   = (r_rows == RW'(HEIGHT_NB - 1));

  // Column the next beat will land on. The RAMs are read one cycle ahead at
  // this address so their registered output is ready when that beat arrives.
  always_comb begin
    w_col_nxt = r_col;
    if (cfg_set) begin
      w_col_nxt = '0;
    end else if (w_accept) begin
      w_col_nxt = w_col_last ? '0 : r_col + 1'b1;
    end
  end

  // Cascade: on a beat at column c, line memory 0 takes the new pixel and
  // line memory g takes what memory g-1 held at c (one line older). The write
  // goes to c at the accepting edge while the lookahead read targets the
  // following column, which differs from c because the width is at least 2,
  // so a column is never read and rewritten on the same edge.
  for (genvar g = 0; g < NM; g++) begin : g_line
    if (g == 0) begin : g_head
      assign w_wr[g] = bus.up_data;
    end else begin : g_tail
      assign w_wr[g] = w_rd[g-1];
    end

    line_mem #(
      .W     (PIX_W),
      .AW    (MEM_AWIDTH),
      .DEPTH (MEM_DEPTH)
    ) u_line_mem (
      .i_clk   (clk),
      .i_we    (w_accept),
      .i_waddr (r_col),
      .i_wdata (w_wr[g]),
      .i_raddr (w_col_nxt),
      .o_rdata (w_rd[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col    <= '0;
      r_rows   <= '0;
      r_width  <= (MEM_AWIDTH+1)'(MEM_DEPTH);
      r_dn_val <= 1'b0;
      r_dn_eol <= 1'b0;
      for (int h = 0; h < HEIGHT_NB; h++) begin
        r_slot[h] <= '0;
      end
    end else if (cfg_set) begin
      r_width  <= (MEM_AWIDTH+1)'(clamp_width(int'(cfg_width), MEM_DEPTH));
      r_col    <= '0;
      r_rows   <= '0;
      r_dn_val <= 1'b0;
      r_dn_eol <= 1'b0;
    end else if (w_accept) begin
      r_col <= w_col_nxt;
      if (w_col_last && !w_primed) begin
        r_rows <= r_rows + 1'b1;
      end
      // Columns from lines before the window is full carry stale memory
      // contents, so they are captured but never presented.
      r_dn_val  <= w_primed;
      r_dn_eol  <= w_col_last;
      r_slot[0] <= bus.up_data;
      for (int h = 1; h < HEIGHT_NB; h++) begin
        r_slot[h] <= w_rd[h-1];
      end
    end else if (bus.dn_rdy) begin
      r_dn_val <= 1'b0;
    end
  end

  always_comb begin
    w_dn_bus = '0;
    for (int h = 0; h < HEIGHT_NB; h++) begin
      w_dn_bus[h*PIX_W +: PIX_W] = r_slot[h];
    end
  end

  assign bus.up_rdy = w_up_rdy;
  assign bus.dn_bus = w_dn_bus;
  assign bus.dn_val = r_dn_val;
  assign bus.dn_eol = r_dn_eol;

endmodule
